coin_select_input: RTL
======================

Name: coin_select_input

Overview:
- Input-side front end of the vending machine. It produces the ProductID, Int, Float and MoneyInput values that the seven-segment display driver consumes.
- Debounces five raw push-buttons: product-next, coin 0.5, coin 1, coin 5 and cancel.
- Cycles the product selection and accumulates inserted money in tenths of a yuan, with a BCD split for display.
- Runs a two-state SELECT/PAY controller with reject and refund pulses.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable-level cycles required before a debounced level changes (10 ms at 100 MHz).
- MAX_TENTHS, 95, maximum accumulated money in tenths of a yuan. Must be ≤ 99.
- TIMEOUT_CYCLES, 500000000, PAY-state inactivity limit in cycles. Used only with AUTO_CANCEL_EN.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz. Only clock in the block.
- reset  input  1  synchronous, active-high reset.
- btn_next  input  1  raw product-next button, asynchronous, bouncy.
- btn_coin05  input  1  raw 0.5-yuan coin button.
- btn_coin1  input  1  raw 1-yuan coin button.
- btn_coin5  input  1  raw 5-yuan coin button.
- btn_cancel  input  1  raw cancel/refund button.
- ProductID  output  3  selected product, 1..6.
- MoneyInput  output  8  accumulated money in tenths, 0..MAX_TENTHS.
- Int  output  4  BCD integer-yuan digit, equal to MoneyInput/10.
- Float  output  4  BCD tenths digit, equal to MoneyInput%10.
- reject  output  1  one-cycle pulse: coin refused because of saturation.
- refund  output  1  one-cycle pulse: money returned, MoneyInput cleared.

Behaviour:
- Clocking and reset: all logic runs on the rising edge of CLK100MHZ. Reset is synchronous and active-high.
- Reset values:
  - ProductID = 1; MoneyInput = 0; Int = 0; Float = 0; reject = 0; refund = 0.
  - State = SELECT.
  - All synchronizers, debounce counters and debounced levels are cleared to 0.
- Input synchronization: each raw button passes through a 2-flop synchronizer.
- Debounce, per button:
  - The counter resets whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press event is a single-cycle 0→1 transition of the debounced level.
  - A release generates no event. Holding a button produces exactly one event.
- Reset mid-press: a button held through reset release yields one press event DEBOUNCE_CYCLES(+sync) cycles after reset deassertion.
- Event priority: if multiple press events occur in the same cycle, priority is cancel > coin5 > coin1 > coin05 > next. Only the highest-priority event is acted on; the others are dropped.
- Latency: outputs update on the clock edge after the press event (registered). Int and Float change in the same cycle as MoneyInput and are always consistent with it.
- Coin values: coin05 = 5, coin1 = 10, coin5 = 50, in tenths.
- SELECT state:
  - next: ProductID advances 1→2→…→6→1 (wrap from 6 to 1).
  - coin: if value ≤ MAX_TENTHS, set MoneyInput = value and go to PAY. Otherwise pulse reject and stay in SELECT.
  - cancel: no action, no refund pulse.
- PAY state:
  - next: ignored; ProductID is frozen while paying.
  - coin: if MoneyInput+value ≤ MAX_TENTHS, add it. Otherwise pulse reject and leave MoneyInput unchanged.
  - An exact hit on MAX_TENTHS is accepted.
  - cancel: pulse refund, clear MoneyInput/Int/Float to 0, go to SELECT.
- Pulses: reject and refund are high for exactly one cycle per event and are never high in the same cycle.
- Arithmetic: the sum is computed at 8 bits, so no overflow is possible given MAX_TENTHS ≤ 99. The Int/Float split comes from registered BCD or an equivalent divide-by-10 on the registered value.
- Illegal state encoding: recover to SELECT with MoneyInput = 0.

Optional Feature:
- Macro AUTO_CANCEL_EN.
- Defined:
  - An inactivity counter runs in PAY and clears on every accepted or rejected coin event.
  - When it reaches TIMEOUT_CYCLES-1 with no event, the block behaves exactly as a cancel: refund pulse, money cleared, return to SELECT.
  - The counter is held at 0 in SELECT and on reset.
  - A cancel press in the same cycle as the timeout produces a single refund pulse.
- Undefined: no counter exists; PAY persists indefinitely until cancel.

Test Plan (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
- Reset, then press btn_next 6 times, each held 20 cycles with 10-cycle bounce glitches → ProductID sequence 2,3,4,5,6,1, one step per press, glitches produce no steps.
- Press coin1, coin05, coin5 → MoneyInput 10, 15, 65; Int/Float 1/0, 1/5, 6/5; state PAY; a btn_next press leaves ProductID unchanged.
- From 65, press coin1 three times → 75, 85, 95 (Int=9, Float=5). Then press coin05 → one-cycle reject, MoneyInput stays 95.
- From 95, press btn_cancel → one-cycle refund, MoneyInput=0, Int=0, Float=0, state SELECT. A second cancel → no refund pulse.
- Press coin5 and btn_next with debounced edges in the same cycle → MoneyInput=50, ProductID unchanged. Assert reset while btn_coin1 is held → all outputs reset, then MoneyInput=10 after the debounce delay.
- AUTO_CANCEL_EN: insert coin05, then wait 50 cycles idle → refund pulse, MoneyInput=0. Without the macro, after 200 cycles MoneyInput is still 5.

Source files
------------

// File: rtl/coin_select_input.sv
// rtl/coin_select_input.sv - vending machine input front end: debounce, product select, coin accumulation
// Optional AUTO_CANCEL_EN: a PAY-state inactivity timeout behaves exactly like a cancel press.
module coin_select_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MAX_TENTHS      = 95,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_coin05,
  input  logic       btn_coin1,
  input  logic       btn_coin5,
  input  logic       btn_cancel,
  output logic [2:0] ProductID,
  output logic [7:0] MoneyInput,
  output logic [3:0] Int,
  output logic [3:0] Float,
  output logic       reject,
  output logic       refund
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      MAX_Q   = 8'(MAX_TENTHS);

  localparam int B_NEXT   = 0;
  localparam int B_COIN05 = 1;
  localparam int B_COIN1  = 2;
  localparam int B_COIN5  = 3;
  localparam int B_CANCEL = 4;

  typedef enum logic [1:0] {
    S_SELECT = 2'b01,
    S_PAY    = 2'b10
  } state_t;

  logic [4:0]      btn_raw;
  logic [4:0]      sync1_q;
  logic [4:0]      sync2_q;
  logic [4:0]      deb_q;
  logic [4:0]      deb_prev_q;
  logic [DB_W-1:0] cnt_q [5];
  logic [4:0]      press;

  assign btn_raw = {btn_cancel, btn_coin5, btn_coin1, btn_coin05, btn_next};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          deb_q[i] <= ~deb_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Only rising debounced edges are events; releases are ignored.
  assign press = deb_q & ~deb_prev_q;

  logic       ev_cancel;
  logic       ev_coin;
  logic       ev_next;
  logic [7:0] coin_val;

  always_comb begin
    ev_cancel = press[B_CANCEL];
    ev_coin   = 1'b0;
    ev_next   = 1'b0;
    coin_val  = 8'd0;
    if (!press[B_CANCEL]) begin
      if (press[B_COIN5]) begin
        ev_coin  = 1'b1;
        coin_val = 8'd50;
      end else if (press[B_COIN1]) begin
        ev_coin  = 1'b1;
        coin_val = 8'd10;
      end else if (press[B_COIN05]) begin
        ev_coin  = 1'b1;
        coin_val = 8'd5;
      end else begin
        ev_next = press[B_NEXT];
      end
    end
  end

  state_t     state_q;
  logic [2:0] product_q;
  logic [7:0] money_q;
  logic [3:0] int_q;
  logic [3:0] frac_q;
  logic       reject_q;
  logic       refund_q;

  logic [7:0] coin_sum;
  logic       coin_fits;
  logic [3:0] sum_int;
  logic [3:0] sum_frac;
  logic       timeout;

  always_comb begin
    coin_sum  = ((state_q == S_PAY) ? money_q : 8'd0) + coin_val;
    coin_fits = (coin_sum <= MAX_Q);
    sum_int   = 4'(coin_sum / 8'd10);
    sum_frac  = 4'(coin_sum % 8'd10);
  end

`ifdef AUTO_CANCEL_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_q;

  always_ff @(posedge CLK100MHZ) begin
    if (reset || state_q != S_PAY || ev_coin) begin
      idle_q <= '0;
    end else if (idle_q != TO_LAST) begin
      idle_q <= idle_q + TO_W'(1);
    end
  end

  // A coin arriving on the timeout cycle counts as activity and wins.
  assign timeout = (state_q == S_PAY) && (idle_q == TO_LAST) && !ev_coin;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q   <= S_SELECT;
      product_q <= 3'd1;
      money_q   <= 8'd0;
      int_q     <= 4'd0;
      frac_q    <= 4'd0;
      reject_q  <= 1'b0;
      refund_q  <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      refund_q <= 1'b0;
      case (state_q)
        S_SELECT: begin
          if (ev_coin) begin
            if (coin_fits) begin
              money_q <= coin_sum;
              int_q   <= sum_int;
              frac_q  <= sum_frac;
              state_q <= S_PAY;
            end else begin
              reject_q <= 1'b1;
            end
          end else if (ev_next) begin
            product_q <= (product_q >= 3'd6) ? 3'd1 : product_q + 3'd1;
          end
        end
        S_PAY: begin
          if (ev_cancel || timeout) begin
            refund_q <= 1'b1;
            money_q  <= 8'd0;
            int_q    <= 4'd0;
            frac_q   <= 4'd0;
            state_q  <= S_SELECT;
          end else if (ev_coin) begin
            if (coin_fits) begin
              money_q <= coin_sum;
              int_q   <= sum_int;
              frac_q  <= sum_frac;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_SELECT;
          money_q <= 8'd0;
          int_q   <= 4'd0;
          frac_q  <= 4'd0;
        end
      endcase
    end
  end

  assign ProductID  = product_q;
  assign MoneyInput = money_q;
  assign Int        = int_q;
  assign Float      = frac_q;
  assign reject     = reject_q;
  assign refund     = refund_q;

endmodule
